dual_input_debouncer: RTL and testbench
=======================================

Name: dual_input_debouncer

Overview:
- Upstream stage for the two-input gate blocks (and_logic and related gates).
- Takes two raw, asynchronous, bouncy inputs (switches/pins), synchronises each into the clock domain and debounces it.
- Presents clean, glitch-free levels a_clean/b_clean that drive the gate's a and b inputs directly.
- Also flags each accepted level change with a one-cycle pulse so downstream logic can count or log events.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from its clean level before the change is accepted; legal range 2..65535.
- CNT_W, 16, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset; no other clock or reset exists.
- a_raw  input  1  raw input A; asynchronous to clk.
- b_raw  input  1  raw input B; asynchronous to clk.
- a_clean  output  1  debounced A; registered.
- b_clean  output  1  debounced B; registered.
- changed  output  2  bit0 = A accepted a new level this cycle, bit1 = B; each bit is a one-cycle pulse.

Behaviour:
- Reset (asynchronous, rst=1):
  - sync flops, counters and channel FSMs cleared.
  - a_clean=0, b_clean=0, changed=2'b00.
  - Outputs hold these values for as long as rst=1, and until the first post-reset clock edge.
- Synchroniser: per channel, two flops s1 <= raw, s2 <= s1. Only s2 is used internally.
- Per-channel FSM, channels fully independent:
  - STABLE:
    - counter=0.
    - If s2 != clean, go to CHECKING with counter <= 1 (or accept immediately if DEBOUNCE_CYCLES==1; not legal, so not required).
  - CHECKING:
    - If s2 == clean: return to STABLE, counter <= 0. This is a glitch, silently dropped.
    - Else if counter == DEBOUNCE_CYCLES-1: clean <= s2, changed bit <= 1 for exactly one cycle, counter <= 0, go to STABLE.
    - Else counter <= counter+1.
- changed bit is 0 in every cycle other than the acceptance cycle.
- Latency: number the first rising edge that samples a new raw level into s1 as edge 1. If raw is held, clean updates at edge DEBOUNCE_CYCLES+2.
  - For the default 4, that is edge 6; changed pulses high during the cycle following edge 6.
- Glitch rule: a raw pulse that results in s2 differing for fewer than DEBOUNCE_CYCLES consecutive cycles never reaches clean and never raises changed.
- Simultaneous events: A and B accepted on the same edge give changed=2'b11 for one cycle, with both clean outputs updated on that edge.
- Back-to-back: after an acceptance the channel is immediately in STABLE.
  - A further reversal of s2 starts a fresh full DEBOUNCE_CYCLES count; there is no hold-off beyond that.
- Reset mid-count: rst asserted while CHECKING discards the count.
  - clean returns to 0 even if the pending level was 0 or 1.
  - After release, a raw input held at 1 is re-qualified from scratch (full DEBOUNCE_CYCLES+2 latency).
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is reachable.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst=1 with a_raw=b_raw=1 for 5 cycles -> a_clean=b_clean=0, changed=00 throughout; asynchronous assert mid-cycle forces outputs to 0 before the next edge.
- Clean rise, default N=4: a_raw 0->1 held, first sampling edge = edge 1 -> a_clean=1 after edge 6, changed=01 for exactly one cycle, b_clean stays 0.
- Glitch rejection: a_raw high for 2 cycles then low -> a_clean stays 0, changed stays 00; a 3-cycle high pulse is also rejected.
- Simultaneous: a_raw and b_raw rise on the same cycle, held -> both clean outputs 1 after edge 6, changed=11 for one cycle; downstream AND output follows to 1.
- Bounce: a_raw toggles 1,0,1,1,0,1,1,1,1,1 -> a_clean rises only 6 edges after the final stable run begins, with a single changed pulse.
- Reset mid-count: a_raw rises; rst pulses after edge 4 -> a_clean=0; after release with a_raw still 1 -> a_clean=1 at edge 6 counted from the first post-reset sampling edge.

Source files
------------

// File: rtl/dual_input_debouncer.sv
// Two independent synchronise-and-debounce channels (A = bit 0, B = bit 1).
// Each channel only accepts a new level after it has been stable for DEBOUNCE_CYCLES cycles.
module dual_input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       a_clean,
    output logic       b_clean,
    output logic [1:0] changed
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHECKING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0] raw_w;
    logic [1:0] clean_w;
    logic [1:0] changed_w;

    assign raw_w = {b_raw, a_raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic             s1_q;
            logic             s2_q;
            logic             clean_q;
            logic             pulse_q;
            state_t           state_q;
            logic [CNT_W-1:0] cnt_q;

            // cnt_q counts consecutive cycles in which s2_q disagreed with clean_q.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_q    <= 1'b0;
                    s2_q    <= 1'b0;
                    clean_q <= 1'b0;
                    pulse_q <= 1'b0;
                    state_q <= ST_STABLE;
                    cnt_q   <= '0;
                end else begin
                    s1_q    <= raw_w[gi];
                    s2_q    <= s1_q;
                    pulse_q <= 1'b0;
                    case (state_q)
                        ST_STABLE: begin
                            cnt_q <= '0;
                            if (s2_q != clean_q) begin
                                state_q <= ST_CHECKING;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                        ST_CHECKING: begin
                            if (s2_q == clean_q) begin
                                // Reverted before qualifying: glitch, drop it silently.
                                state_q <= ST_STABLE;
                                cnt_q   <= '0;
                            end else if (cnt_q == CNT_LAST) begin
                                clean_q <= s2_q;
                                pulse_q <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= ST_STABLE;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end
                        default: begin
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end
                    endcase
                end
            end

            assign clean_w[gi]   = clean_q;
            assign changed_w[gi] = pulse_q;
        end
    endgenerate

    assign a_clean = clean_w[0];
    assign b_clean = clean_w[1];
    assign changed = changed_w;

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Directed and randomized bench for dual_input_debouncer, checked against a
// sliding-window model: a level is accepted once the last N synchronised samples all disagree with it.
module tb_dual_input_debouncer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_raw;
    logic       b_raw;
    logic       a_clean;
    logic       b_clean;
    logic [1:0] changed;

    int tests = 0;
    int fails = 0;

    bit m_clean [2];
    bit m_chg   [2];
    bit hist    [2][$];
    bit win     [2][$];

    dual_input_debouncer #(.DEBOUNCE_CYCLES(N), .CNT_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_raw   (a_raw),
        .b_raw   (b_raw),
        .a_clean (a_clean),
        .b_clean (b_clean),
        .changed (changed)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_clean[c] = 1'b0;
            m_chg[c]   = 1'b0;
            hist[c].delete();
            hist[c].push_back(1'b0);
            hist[c].push_back(1'b0);
            win[c].delete();
        end
    endfunction

    // Raw levels reach the debounce logic two edges after they are sampled.
    function automatic void model_edge(bit a, bit b);
        bit r [2];
        r[0] = a;
        r[1] = b;
        for (int c = 0; c < 2; c++) begin
            bit seen;
            bit all_differ;
            hist[c].push_back(r[c]);
            seen = hist[c].pop_front();
            win[c].push_back(seen);
            if (win[c].size() > N) void'(win[c].pop_front());
            m_chg[c] = 1'b0;
            if (win[c].size() == N) begin
                all_differ = 1'b1;
                foreach (win[c][k]) if (win[c][k] == m_clean[c]) all_differ = 1'b0;
                if (all_differ) begin
                    m_clean[c] = ~m_clean[c];
                    m_chg[c]   = 1'b1;
                end
            end
        end
    endfunction

    task automatic check(string tag, string name, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
        end
    endtask

    task automatic check_model(string tag);
        check(tag, "a_clean", 32'(a_clean), 32'(m_clean[0]));
        check(tag, "b_clean", 32'(b_clean), 32'(m_clean[1]));
        check(tag, "changed", 32'(changed), 32'({m_chg[1], m_chg[0]}));
    endtask

    task automatic step(bit a, bit b, string tag);
        a_raw = a;
        b_raw = b;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(a, b);
        #1;
        check_model(tag);
    endtask

    task automatic settle(string tag);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, tag);
    endtask

    initial begin
        int pulses;
        int rise_edge;
        int hold_a;
        int hold_b;
        bit lvl_a;
        bit lvl_b;
        bit bounce [10];

        rst   = 1'b1;
        a_raw = 1'b1;
        b_raw = 1'b1;
        model_reset();

        // Reset held with both raw inputs high.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, "reset_hold");
            check("reset_hold", "outs", 32'({a_clean, b_clean, changed}), 32'd0);
        end
        rst = 1'b0;
        $display("[TB] reset hold done");
        settle("settle0");

        // Clean rise on A only.
        for (int e = 1; e <= 8; e++) begin
            step(1'b1, 1'b0, "rise");
            if (e == 5) check("rise_e5", "a_clean", 32'(a_clean), 32'd0);
            if (e == 6) check("rise_e6", "a_b_chg", 32'({a_clean, b_clean, changed}), 32'b1001);
            if (e == 7) check("rise_e7", "changed", 32'(changed), 32'd0);
        end
        $display("[TB] clean rise on A done");
        settle("fall");

        // Two- and three-cycle glitches must be rejected.
        for (int w = 2; w <= 3; w++) begin
            for (int i = 0; i < w; i++) step(1'b1, 1'b0, "glitch_hi");
            for (int i = 0; i < 8; i++) begin
                step(1'b0, 1'b0, "glitch_lo");
                check("glitch", "a_chg", 32'({a_clean, changed}), 32'd0);
            end
            $display("[TB] glitch width %0d done", w);
        end

        // Simultaneous rise on both channels.
        for (int e = 1; e <= 8; e++) begin
            step(1'b1, 1'b1, "simul");
            if (e == 6) begin
                check("simul_e6", "changed", 32'(changed), 32'b11);
                check("simul_e6", "and_out", 32'(a_clean & b_clean), 32'd1);
            end
        end
        $display("[TB] simultaneous rise done");

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", "outs", 32'({a_clean, b_clean, changed}), 32'd0);
        model_reset();
        step(1'b1, 1'b1, "async_rst_hold");
        step(1'b1, 1'b1, "async_rst_hold");
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step(1'b1, 1'b1, "requal");
            if (e == 5) check("requal_e5", "clean", 32'({a_clean, b_clean}), 32'd0);
            if (e == 6) check("requal_e6", "clean", 32'({a_clean, b_clean}), 32'b11);
        end
        $display("[TB] async reset and requalify done");
        settle("settle1");

        // Bouncing A: final stable run starts at pattern edge 6.
        bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
        pulses    = 0;
        rise_edge = 0;
        for (int e = 1; e <= 14; e++) begin
            step(e <= 10 ? bounce[e-1] : 1'b1, 1'b0, "bounce");
            if (changed[0] === 1'b1) pulses++;
            if (a_clean === 1'b1 && rise_edge == 0) rise_edge = e;
        end
        check("bounce", "pulses", 32'(pulses), 32'd1);
        check("bounce", "rise_edge", 32'(rise_edge), 32'd11);
        $display("[TB] bounce sequence done");
        settle("settle2");

        // Reset during A's qualification window discards the count.
        for (int e = 1; e <= 4; e++) step(1'b1, 1'b0, "midcnt");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midcnt_rst", "a_clean", 32'(a_clean), 32'd0);
        step(1'b1, 1'b0, "midcnt_hold");
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step(1'b1, 1'b0, "midcnt_requal");
            if (e == 5) check("midcnt_e5", "a_clean", 32'(a_clean), 32'd0);
            if (e == 6) check("midcnt_e6", "a_chg", 32'({a_clean, changed}), 32'b101);
        end
        $display("[TB] reset mid-count done");

        // Randomized hold lengths straddling the debounce threshold.
        lvl_a  = 1'b1;
        lvl_b  = 1'b0;
        hold_a = 0;
        hold_b = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold_a == 0) begin
                lvl_a  = 1'($urandom);
                hold_a = int'($urandom_range(1, 8));
            end
            if (hold_b == 0) begin
                lvl_b  = 1'($urandom);
                hold_b = int'($urandom_range(1, 8));
            end
            step(lvl_a, lvl_b, "random");
            hold_a--;
            hold_b--;
        end
        $display("[TB] random phase done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
